// File: rtl/mb8_console.sv
// mb8_console: memory-mapped console with RX (host->core) and TX (core->host) byte FIFOs.
// Optional echo path: define MB8_CON_ECHO_EN to copy each accepted RX byte into the TX FIFO.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   bus_a, bus_we, bus_vi      core byte bus address, write strobe, write data
//   bus_vo, bus_hit            registered read data and window-hit flag
//   rx_valid, rx_ready, rx_data  host -> core stream into the RX FIFO
//   tx_valid, tx_ready, tx_data  core -> host stream out of the TX FIFO (show-ahead)
// Registers: 0 RXD, 1 STAT, 2 TXD, 3 RXCNT.
module mb8_console #(
  parameter int BASE  = 'h1800,
  parameter int ASZ   = 17,
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [ASZ-1:0] bus_a,
  input  logic           bus_we,
  input  logic [7:0]     bus_vi,
  output logic [7:0]     bus_vo,
  output logic           bus_hit,
  input  logic           rx_valid,
  output logic           rx_ready,
  input  logic [7:0]     rx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic [7:0]     tx_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [ASZ-1:0] BASE_A = ASZ'(BASE);

  logic [7:0] rx_mem [DEPTH];
  logic [7:0] tx_mem [DEPTH];
  logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d, tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d, bus_hit_q, bus_hit_d;
  logic [7:0] bus_vo_q, bus_vo_d, stat, rd_val, tx_wdata;
  logic hit, wr_rxd, wr_stat, wr_txd;
  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_push, rx_pop, tx_push, tx_pop, tx_ovf_set;

  assign hit      = bus_a[ASZ-1:2] == BASE_A[ASZ-1:2];
  assign wr_rxd   = hit && bus_we && bus_a[1:0] == 2'd0;
  assign wr_stat  = hit && bus_we && bus_a[1:0] == 2'd1;
  assign wr_txd   = hit && bus_we && bus_a[1:0] == 2'd2;
  assign rx_empty = rx_cnt_q == '0;
  assign rx_full  = rx_cnt_q == CW'(DEPTH);
  assign tx_empty = tx_cnt_q == '0;
  assign tx_full  = tx_cnt_q == CW'(DEPTH);
  assign rx_push  = rx_valid && !rx_full;
  assign rx_pop   = wr_rxd && !rx_empty;
  assign tx_pop   = tx_ready && !tx_empty;

`ifdef MB8_CON_ECHO_EN
  // A core TXD write owns the TX write port; a colliding echo byte is lost and flagged.
  assign tx_push    = wr_txd ? !tx_full : rx_push && !tx_full;
  assign tx_wdata   = wr_txd ? bus_vi : rx_data;
  assign tx_ovf_set = (wr_txd && tx_full) || (rx_push && (tx_full || wr_txd));
`else
  // A full TX FIFO drops the write even if the host pops in the same cycle.
  assign tx_push    = wr_txd && !tx_full;
  assign tx_wdata   = bus_vi;
  assign tx_ovf_set = wr_txd && tx_full;
`endif

  assign stat     = {3'b000, tx_ovf_q, tx_empty, rx_ovf_q, tx_full, !rx_empty};
  assign rd_val   = bus_a[1:0] == 2'd0 ? (rx_empty ? 8'h00 : rx_mem[rx_rd_q]) :
                    bus_a[1:0] == 2'd1 ? stat :
                    bus_a[1:0] == 2'd3 ? 8'(rx_cnt_q) : 8'h00;
  assign rx_ready = !rx_full;
  assign tx_valid = !tx_empty;
  assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd_q];
  assign bus_vo   = bus_vo_q;
  assign bus_hit  = bus_hit_q;

  always_comb begin
    rx_wr_d   = rx_push ? rx_wr_q + AW'(1) : rx_wr_q;
    rx_rd_d   = rx_pop ? rx_rd_q + AW'(1) : rx_rd_q;
    rx_cnt_d  = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    tx_wr_d   = tx_push ? tx_wr_q + AW'(1) : tx_wr_q;
    tx_rd_d   = tx_pop ? tx_rd_q + AW'(1) : tx_rd_q;
    tx_cnt_d  = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    // A new overflow in the same cycle as a clear keeps the flag set.
    rx_ovf_d  = (rx_ovf_q && !(wr_stat && bus_vi[2])) || (rx_valid && rx_full);
    tx_ovf_d  = (tx_ovf_q && !(wr_stat && bus_vi[4])) || tx_ovf_set;
    bus_hit_d = hit;
    bus_vo_d  = hit ? rd_val : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
      rx_cnt_q  <= '0;
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      tx_cnt_q  <= '0;
      rx_ovf_q  <= 1'b0;
      tx_ovf_q  <= 1'b0;
      bus_hit_q <= 1'b0;
      bus_vo_q  <= 8'h00;
    end else begin
      rx_wr_q   <= rx_wr_d;
      rx_rd_q   <= rx_rd_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_wr_q   <= tx_wr_d;
      tx_rd_q   <= tx_rd_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_ovf_q  <= rx_ovf_d;
      tx_ovf_q  <= tx_ovf_d;
      bus_hit_q <= bus_hit_d;
      bus_vo_q  <= bus_vo_d;
    end
  end

  // Storage has no reset; occupancy is tracked by the counts alone.
  always_ff @(posedge clk) begin
    if (rst_n && rx_push) rx_mem[rx_wr_q] <= rx_data;
    if (rst_n && tx_push) tx_mem[tx_wr_q] <= tx_wdata;
  end
endmodule

// File: tb/tb_mb8_console.sv
// tb_mb8_console: directed scoreboard bench for mb8_console.
module tb_mb8_console;
  localparam int BASE = 'h1800;
  localparam logic [16:0] A_RXD = 17'h1800, A_STAT = 17'h1801, A_TXD = 17'h1802, A_CNT = 17'h1803;

  logic clk = 1'b0, rst_n = 1'b0, bus_we = 1'b0, bus_hit, rx_valid = 1'b0, rx_ready;
  logic tx_valid, tx_ready = 1'b0;
  logic [16:0] bus_a = '0;
  logic [7:0] bus_vi = '0, bus_vo, rx_data = '0, tx_data;
  int checks = 0, failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_model[$];
  logic [7:0] tx_model[$];

  mb8_console #(.BASE(BASE), .ASZ(17), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus_a(bus_a), .bus_we(bus_we), .bus_vi(bus_vi),
    .bus_vo(bus_vo), .bus_hit(bus_hit), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_data(rx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    e = exp_q.pop_front();
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, e);
    end
  endtask

  task automatic rd(input logic [16:0] a, input logic [7:0] e, input string tag);
    bus_a = a;
    bus_we = 1'b0;
    exp_q.push_back(e);
    exp_q.push_back(8'((a >> 2) == 17'(BASE >> 2)));
    @(negedge clk);
    chk(tag, bus_vo);
    chk({tag, "_hit"}, {7'b0, bus_hit});
  endtask

  task automatic wr(input logic [16:0] a, input logic [7:0] d);
    bus_a = a;
    bus_we = 1'b1;
    bus_vi = d;
    if (a == A_RXD && rx_model.size() > 0) void'(rx_model.pop_front());
    if (a == A_TXD && tx_model.size() < 16) tx_model.push_back(d);
    @(negedge clk);
    bus_we = 1'b0;
  endtask

  task automatic host(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data = d;
    if (rx_model.size() < 16) rx_model.push_back(d);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic rd_rxd(input string tag);
    rd(A_RXD, rx_model.size() > 0 ? rx_model[0] : 8'h00, tag);
  endtask

  task automatic reset_outs(input string tag);
    exp_q.push_back(8'h00); chk({tag, "_vo"}, bus_vo);
    exp_q.push_back(8'h00); chk({tag, "_hit"}, {7'b0, bus_hit});
    exp_q.push_back(8'h01); chk({tag, "_rx_ready"}, {7'b0, rx_ready});
    exp_q.push_back(8'h00); chk({tag, "_tx_valid"}, {7'b0, tx_valid});
    exp_q.push_back(8'h00); chk({tag, "_tx_data"}, tx_data);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    reset_outs("reset");
    rst_n = 1'b1;
    rd(A_STAT, 8'h08, "stat_reset");
    rd(A_CNT, 8'h00, "cnt_reset");
    rd(17'h0000, 8'h00, "out_of_window");
    rd(17'h1804, 8'h00, "past_window");
    host(8'h41);
    host(8'h42);
    rd_rxd("rxd_peek1");
    rd_rxd("rxd_peek2");
    wr(A_RXD, 8'h00);
    rd_rxd("rxd_after_pop");
    rd(A_CNT, 8'd1, "cnt_after_pop");
    wr(A_RXD, 8'h00);
    wr(A_RXD, 8'h00);
    rd(A_CNT, 8'd0, "cnt_empty_pop");
    rd(A_TXD, 8'h00, "txd_read_zero");
    for (int i = 0; i < 16; i++) host(8'(8'h60 + i));
    exp_q.push_back(8'h00); chk("rx_ready_full", {7'b0, rx_ready});
    rd(A_CNT, 8'd16, "cnt_full");
    host(8'hEE);
    rd(A_STAT, 8'h0D, "stat_rx_ovf");
    rd(A_CNT, 8'd16, "cnt_after_ovf");
    rd_rxd("rxd_head_full");
    wr(A_STAT, 8'h04);
    rd(A_STAT, 8'h09, "stat_ovf_clear");
    for (int i = 0; i < 13; i++) wr(A_RXD, 8'h00);
    rd(A_CNT, 8'd3, "cnt_three");
    bus_a = A_RXD;
    bus_we = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h77;
    void'(rx_model.pop_front());
    rx_model.push_back(8'h77);
    @(negedge clk);
    bus_we = 1'b0;
    rx_valid = 1'b0;
    rd(A_CNT, 8'd3, "cnt_push_pop");
    rd_rxd("rxd_6e");
    wr(A_RXD, 8'h00);
    rd_rxd("rxd_6f");
    wr(A_RXD, 8'h00);
    rd_rxd("rxd_wrapped_77");
    for (int i = 0; i < 16; i++) wr(A_TXD, 8'(8'h31 + i));
    wr(A_TXD, 8'h55);
    rd(A_STAT, 8'h13, "stat_tx_full_ovf");
    @(negedge clk);
    exp_q.push_back(8'h31); chk("tx_data_stable", tx_data);
    exp_q.push_back(8'h01); chk("tx_valid_full", {7'b0, tx_valid});
    tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(tx_model.pop_front());
      chk("tx_drain", tx_data);
      @(negedge clk);
    end
    tx_ready = 1'b0;
    exp_q.push_back(8'h00); chk("tx_valid_drained", {7'b0, tx_valid});
    wr(A_STAT, 8'h10);
    rd(A_STAT, 8'h09, "stat_tx_ovf_clear");
    wr(A_TXD, 8'hA0);
    wr(A_TXD, 8'hA1);
    wr(A_TXD, 8'hA2);
    exp_q.push_back(tx_model[0]); chk("tx_wrap_head", tx_data);
    tx_ready = 1'b1;
    @(negedge clk);
    void'(tx_model.pop_front());
    exp_q.push_back(tx_model[0]); chk("tx_wrap_next", tx_data);
    rst_n = 1'b0;
    bus_a = A_STAT;
    @(negedge clk);
    reset_outs("mid_reset");
    tx_ready = 1'b0;
    rst_n = 1'b1;
    rx_model.delete();
    tx_model.delete();
    rd(A_STAT, 8'h08, "stat_after_reset");
    rd(A_CNT, 8'd0, "cnt_after_reset");
`ifdef MB8_CON_ECHO_EN
    host(8'h5A);
    exp_q.push_back(8'h01); chk("echo_tx_valid", {7'b0, tx_valid});
    exp_q.push_back(8'h5A); chk("echo_tx_data", tx_data);
    rd(A_CNT, 8'd1, "echo_cnt");
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
